// File: rtl/rv_mem_arb.sv
// rv_mem_arb: two-port (fetch / data) arbiter onto a single-port memory bus.
// Data port has priority. Fetch is forced through after STARVE_MAX consecutive
// data wins while fetch waits. At most one read is outstanding. A request that
// is stalled by mem_gnt keeps its owner locked until it is accepted.
module rv_mem_arb #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic                clk,
  input  logic                rst,
  // fetch port
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  // data port
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,
  // memory port
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t     state_q, state_d;
  logic       lock_q, lock_d;          // owner frozen while mem_gnt stalls
  logic       lock_dm_q, lock_dm_d;    // locked owner: 1 = data port
  logic       resp_dm_q, resp_dm_d;    // owner of outstanding read: 1 = data port
  logic [3:0] starve_q, starve_d;

  logic sel_dm, issue, gnt, rsp, starve_hit;

  // Owner selection and issue qualification; everything is gated by reset
  always_comb begin
    starve_hit = (starve_q == 4'(STARVE_MAX));
    if (lock_q) sel_dm = lock_dm_q;
    else        sel_dm = dm_req & ~(if_req & starve_hit);
    issue = rst & (state_q == IDLE) & (if_req | dm_req);
    gnt   = issue & mem_gnt;
    rsp   = rst & (state_q == RESP) & mem_rvalid;
  end

  // Memory bus and per-port responses; buses are zero when nothing is issued
  always_comb begin
    mem_req   = issue;
    mem_we    = issue & sel_dm & dm_we;
    mem_addr  = issue ? (sel_dm ? dm_addr : if_addr) : '0;
    mem_wdata = (issue & sel_dm) ? dm_wdata : '0;
    mem_be    = issue ? (sel_dm ? dm_be : '1) : '0;
    if_gnt    = gnt & ~sel_dm;
    dm_gnt    = gnt & sel_dm;
    if_rvalid = rsp & ~resp_dm_q;
    dm_rvalid = rsp & resp_dm_q;
    if_rdata  = if_rvalid ? mem_rdata : '0;
    dm_rdata  = dm_rvalid ? mem_rdata : '0;
    busy      = rst & ((state_q == RESP) | issue);
  end

  // Next-state: issue/response sequencing, owner lock, starvation counter
  always_comb begin
    state_d   = state_q;
    lock_d    = lock_q;
    lock_dm_d = lock_dm_q;
    resp_dm_d = resp_dm_q;
    starve_d  = starve_q;
    case (state_q)
      IDLE: begin
        if (gnt) begin
          lock_d = 1'b0;
          // writes complete on grant; reads wait for their response
          if (!sel_dm || !dm_we) begin
            state_d   = RESP;
            resp_dm_d = sel_dm;
          end
        end else if (issue) begin
          lock_d    = 1'b1;
          lock_dm_d = sel_dm;
        end
      end
      RESP: if (mem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!if_req)                                   starve_d = '0;
    else if (if_gnt)                               starve_d = '0;
    else if (dm_gnt && starve_q < 4'(STARVE_MAX))  starve_d = starve_q + 4'd1;
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      lock_q    <= 1'b0;
      lock_dm_q <= 1'b0;
      resp_dm_q <= 1'b0;
      starve_q  <= '0;
    end else begin
      state_q   <= state_d;
      lock_q    <= lock_d;
      lock_dm_q <= lock_dm_d;
      resp_dm_q <= resp_dm_d;
      starve_q  <= starve_d;
    end
  end

endmodule

// File: tb/tb_rv_mem_arb.sv
// Bench for rv_mem_arb: reset check, table of single-cycle issue vectors,
// directed multi-cycle sequences, then randomized traffic against a model.
module tb_rv_mem_arb;
  localparam int AW = 32, DW = 32, BW = DW/8, SM = 2;

  logic          clk = 1'b0, rst = 1'b0;
  logic          if_req, dm_req, dm_we, mem_gnt, mem_rvalid;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata, mem_rdata;
  logic [BW-1:0] dm_be;
  logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_req, mem_we, busy;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_be;

  rv_mem_arb #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0;
    dm_wdata = '0; dm_be = '0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic to_neg();  @(negedge clk); endtask
  task automatic to_next(); @(posedge clk); #1; endtask

  task automatic do_reset();
    rst = 0; idle_in();
    repeat (2) @(posedge clk);
    #1 rst = 1;
  endtask

  // outputs that must all be zero during reset, packed into one word
  function automatic logic [6:0] flags();
    return {mem_req, if_gnt, dm_gnt, if_rvalid, dm_rvalid, busy, mem_we};
  endfunction

  typedef struct {
    logic ir, dr, dwe, mg; logic [3:0] be;
    logic e_mreq, e_ig, e_dg, e_we; logic [31:0] e_addr; logic [3:0] e_be; logic [31:0] e_wd;
  } vec_t;
  vec_t vt[7];

  // reference model state
  int m_pend, m_lock, m_starve;
  int grant_seq[6] = '{1, 1, 0, 1, 1, 0};  // 1 = data, 0 = fetch

  initial begin
    idle_in();
    // reset with every input active: outputs must stay zero
    rst = 0; if_req = 1; dm_req = 1; dm_we = 1; mem_gnt = 1; mem_rvalid = 1;
    if_addr = 32'h11; dm_addr = 32'h22; dm_be = 4'hF; dm_wdata = 32'h33; mem_rdata = 32'h44;
    to_neg();
    chk("reset flags", flags(), 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_wdata/be", {mem_wdata, mem_be}, 0);
    chk("reset rdata", {if_rdata, dm_rdata}, 0);

    // ---- table vectors, each from a fresh reset ----
    vt[0] = '{0,0,0,1,4'hF, 0,0,0,0, 32'h0,    4'h0, 32'h0};
    vt[1] = '{1,0,1,1,4'h5, 1,1,0,0, 32'h1000, 4'hF, 32'h0};
    vt[2] = '{1,0,0,0,4'h5, 1,0,0,0, 32'h1000, 4'hF, 32'h0};
    vt[3] = '{0,1,1,1,4'h3, 1,0,1,1, 32'h2000, 4'h3, 32'hA5A50F0F};
    vt[4] = '{0,1,0,0,4'h6, 1,0,0,0, 32'h2000, 4'h6, 32'hA5A50F0F};
    vt[5] = '{1,1,1,1,4'hC, 1,0,1,1, 32'h2000, 4'hC, 32'hA5A50F0F};
    vt[6] = '{1,1,0,0,4'h1, 1,0,0,0, 32'h2000, 4'h1, 32'hA5A50F0F};
    for (int i = 0; i < 7; i++) begin
      do_reset();
      if_req = vt[i].ir; dm_req = vt[i].dr; dm_we = vt[i].dwe; mem_gnt = vt[i].mg;
      dm_be = vt[i].be; if_addr = 32'h1000; dm_addr = 32'h2000; dm_wdata = 32'hA5A50F0F;
      to_neg();
      chk($sformatf("vec%0d req/gnt", i), {mem_req, if_gnt, dm_gnt},
          {vt[i].e_mreq, vt[i].e_ig, vt[i].e_dg});
      if (vt[i].e_mreq) begin
        chk($sformatf("vec%0d addr", i), mem_addr, vt[i].e_addr);
        chk($sformatf("vec%0d we/be", i), {mem_we, mem_be}, {vt[i].e_we, vt[i].e_be});
        chk($sformatf("vec%0d wdata", i), mem_wdata, vt[i].e_wd);
      end
    end

    // ---- single fetch ----
    do_reset();
    if_req = 1; if_addr = 32'h100; mem_gnt = 1;
    to_neg();
    chk("fetch c0 gnt", {mem_req, if_gnt, dm_gnt}, 3'b110);
    chk("fetch c0 addr", mem_addr, 32'h100);
    to_next(); if_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    to_neg();
    chk("fetch c1 rvalid", {if_rvalid, dm_rvalid, mem_req, busy}, 4'b1001);
    chk("fetch c1 rdata", {if_rdata, dm_rdata}, {32'hDEADBEEF, 32'h0});
    to_next(); mem_rvalid = 0;
    to_neg();
    chk("fetch c2 idle", {if_rvalid, busy}, 2'b00);

    // ---- collision: data write then fetch without waiting ----
    do_reset();
    if_req = 1; if_addr = 32'h300;
    dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'h12345678; dm_be = 4'b0011;
    mem_gnt = 1;
    to_neg();
    chk("coll c0 gnt", {if_gnt, dm_gnt}, 2'b01);
    chk("coll c0 we/be", {mem_we, mem_be}, {1'b1, 4'b0011});
    chk("coll c0 addr/wdata", {mem_addr, mem_wdata}, {32'h200, 32'h12345678});
    to_next(); dm_req = 0;
    to_neg();
    chk("coll c1 gnt", {if_gnt, dm_gnt}, 2'b10);
    chk("coll c1 fetch bus", {mem_we, mem_be, mem_addr}, {1'b0, 4'hF, 32'h300});
    to_next(); if_req = 0; mem_gnt = 0; mem_rvalid = 1;
    to_neg();
    chk("coll c2 rvalid", {if_rvalid, dm_rvalid}, 2'b10);

    // ---- starvation: D,D,F then counter restarts ----
    do_reset();
    if_req = 1; if_addr = 32'h400; dm_req = 1; dm_we = 0; dm_addr = 32'h500; mem_gnt = 1;
    for (int k = 0; k < 6; k++) begin
      to_neg();
      chk($sformatf("starve grant%0d", k), {if_gnt, dm_gnt},
          {grant_seq[k] == 0, grant_seq[k] == 1});
      to_next(); mem_rvalid = 1; mem_rdata = 32'(k);
      to_neg();
      chk($sformatf("starve rvalid%0d", k), {if_rvalid, dm_rvalid, mem_req},
          {grant_seq[k] == 0, grant_seq[k] == 1, 1'b0});
      to_next(); mem_rvalid = 0;
    end

    // ---- lock: stalled fetch keeps the bus while data arrives ----
    do_reset();
    if_req = 1; if_addr = 32'h40; mem_gnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin dm_req = 1; dm_we = 1; dm_addr = 32'h80; dm_be = 4'hF; end
      if (c == 3) mem_gnt = 1;
      to_neg();
      chk($sformatf("lock c%0d bus", c), {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h40});
      chk($sformatf("lock c%0d gnt", c), {if_gnt, dm_gnt}, {c == 3, 1'b0});
      to_next();
    end
    if_req = 0;
    to_neg();
    chk("lock resp wait", {dm_gnt, mem_req}, 2'b00);
    to_next(); mem_rvalid = 1;
    to_neg();
    chk("lock resp", {if_rvalid, dm_gnt}, 2'b10);
    to_next(); mem_rvalid = 0;
    to_neg();
    chk("lock dm after", {dm_gnt, mem_we, mem_addr}, {1'b1, 1'b1, 32'h80});
    to_next(); idle_in();

    // ---- reset during outstanding read ----
    do_reset();
    dm_req = 1; dm_we = 0; dm_addr = 32'h600; mem_gnt = 1;
    to_neg();
    chk("rstresp grant", dm_gnt, 1);
    to_next(); dm_req = 0; rst = 0; if_req = 1; if_addr = 32'h9;
    to_neg();
    chk("rstresp flags", flags(), 0);
    chk("rstresp buses", {mem_addr, mem_be}, 0);
    to_next(); rst = 1; if_req = 0; mem_gnt = 0;
    to_neg();
    chk("rstresp busy", busy, 0);
    to_next(); mem_rvalid = 1; mem_rdata = 32'h55;
    to_neg();
    chk("rstresp late rvalid", {dm_rvalid, if_rvalid, busy, dm_rdata}, 0);
    to_next(); mem_rvalid = 0;

    // ---- stray response in IDLE ----
    do_reset();
    mem_rvalid = 1; mem_rdata = 32'h77;
    to_neg();
    chk("stray rvalid", {if_rvalid, dm_rvalid, busy, if_rdata}, 0);
    to_next(); mem_rvalid = 0; if_req = 1; if_addr = 32'h700; mem_gnt = 1;
    to_neg();
    chk("stray still idle", {if_gnt, mem_addr}, {1'b1, 32'h700});
    to_next(); idle_in();

    // ---- randomized traffic vs. model ----
    do_reset();
    m_pend = -1; m_lock = -1; m_starve = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic e_mreq, e_ig, e_dg, e_irv, e_drv, e_dsel;
      logic [31:0] e_ird, e_drd;
      to_neg();
      e_mreq = 0; e_ig = 0; e_dg = 0; e_irv = 0; e_drv = 0; e_dsel = 0; e_ird = 0; e_drd = 0;
      if (m_pend >= 0) begin
        if (mem_rvalid) begin
          if (m_pend == 1) begin e_drv = 1; e_drd = mem_rdata; end
          else             begin e_irv = 1; e_ird = mem_rdata; end
        end
      end else if (if_req || dm_req) begin
        e_mreq = 1;
        if (m_lock >= 0)                     e_dsel = (m_lock == 1);
        else if (if_req && m_starve == SM)   e_dsel = 0;
        else                                 e_dsel = dm_req;
        e_dg = mem_gnt & e_dsel;
        e_ig = mem_gnt & ~e_dsel;
      end
      chk("rand ctl", {mem_req, if_gnt, dm_gnt, if_rvalid, dm_rvalid, busy},
          {e_mreq, e_ig, e_dg, e_irv, e_drv, e_mreq || m_pend >= 0});
      chk("rand rdata", {if_rdata, dm_rdata}, {e_ird, e_drd});
      if (e_mreq) begin
        chk("rand addr", mem_addr, e_dsel ? dm_addr : if_addr);
        chk("rand we/be/wd", {mem_we, mem_be, mem_wdata},
            e_dsel ? {dm_we, dm_be, dm_wdata} : {1'b0, 4'hF, 32'h0});
      end
      // model update
      if (m_pend >= 0) begin
        if (mem_rvalid) m_pend = -1;
      end else if (e_ig || e_dg) begin
        m_lock = -1;
        if (e_ig || !dm_we) m_pend = e_dsel ? 1 : 0;
      end else if (e_mreq) m_lock = e_dsel ? 1 : 0;
      if (!if_req || e_ig) m_starve = 0;
      else if (e_dg && m_starve < SM) m_starve++;
      to_next();
      if (e_ig) if_req = 0;
      if (!if_req && ($urandom % 2 == 0)) begin if_req = 1; if_addr = $urandom; end
      if (e_dg) dm_req = 0;
      if (!dm_req && ($urandom % 2 == 0)) begin
        dm_req = 1; dm_we = $urandom % 2; dm_addr = $urandom; dm_wdata = $urandom; dm_be = 4'($urandom);
      end
      mem_gnt = ($urandom % 4) != 0;
      mem_rvalid = $urandom % 2;
      mem_rdata = $urandom;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
